dmux_stream: RTL and testbench
==============================

Name: dmux_stream

Overview:
- Parametrised, registered N-way demultiplexer with valid/ready handshake. It is the sequential successor of the combinational 8-way demux in the Hack chip set.
- A WIDTH-bit word presented on the input is steered to one of 2**SEL_W output channels, or to all channels in broadcast mode.
- Each channel has a one-entry output buffer, so downstream stalls on one channel do not corrupt the others.
- Sits between the Hack CPU data path and peripheral/memory-mapped sinks that need back-pressure.

Parameters:
- WIDTH, 16: data word width in bits.
- SEL_W, 3: select width; channel count N = 2**SEL_W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver word to every channel; in_sel ignored.
- out_valid  output  N  per-channel buffer-full flag.
- out_ready  input  N  per-channel downstream ready.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All out_valid = 0 and all out_data slices = 0.
  - busy = 0.
  - in_ready reflects the empty buffers one cycle later: combinationally 1 once reset is released.
  - Reset mid-transfer discards all buffered words with no output handshake.
- Channel buffer k is "free" when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 (drain and refill in the same cycle, no bubble).
- in_ready is combinational:
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = AND over all free[k].
- Accept = in_valid & in_ready.
- On an accept edge, each targeted buffer loads in_data and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- On a drain (out_valid[k]&out_ready[k]) with no load into k: out_valid[k] clears and the out_data slice returns to 0. Idle channels always present zero, matching classic demux semantics.
- Simultaneous drain and load of the same channel: the new word replaces the old one and out_valid stays 1.
- Untargeted channels are unaffected by an accept. They drain independently.
- Broadcast is all-or-nothing: there is no partial delivery. in_ready stays low until every buffer is free.
- in_sel, in_data and in_bcast may change freely while in_valid=0. While in_valid=1 and in_ready=0, the upstream holds them stable (standard valid/ready rule). The block does not check this.
- Throughput: one word per cycle per channel when downstream is always ready.
- out_ready on an empty channel is ignored.
- busy = |out_valid, registered view (no combinational path from the inputs).

Decomposition:
- Package dmux_stream_pkg holds:
  - the default WIDTH/SEL_W constants;
  - the localparam N derivation function;
  - a slice-index helper for out_data packing.
- Natural sub-module stream_slot: one-entry buffer with load, data_in, ready_in, valid_out, data_out and free_out. It is instantiated N times via generate.
- Top level holds the one-hot decode of in_sel (including bcast override), the in_ready reduction and output packing.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with in_valid=1 → all out_valid=0, out_data=0, busy=0. Release → in_ready=1.
- Single route, defaults: in_sel=5, in_data=16'hBEEF, in_valid=1 for one cycle, all out_ready=0 → next cycle out_valid=8'b0010_0000 and slice 5=16'hBEEF, other slices 0. Then raise out_ready[5] → out_valid=0 next cycle.
- Back-pressure:
  - Channel 2 full with out_ready[2]=0; present in_sel=2 → in_ready=0, word held.
  - Present in_sel=3 instead → in_ready=1, accepted.
  - Set out_ready[2]=1 with in_sel=2, data 16'h0002 → same-cycle drain+load, out_valid[2] stays 1, slice updates.
- Broadcast:
  - Channel 7 full/stalled; in_bcast=1, data 16'h1234 → in_ready=0 and no channel loads.
  - Release channel 7 → all 8 out_valid=1, all slices 16'h1234.
- Streaming: 64 random words with random in_sel and random out_ready (≈50%) → scoreboard per channel sees every word in order, none dropped or duplicated. Channels with out_ready held at 1 accept one word per cycle.
- Parametric: WIDTH=8, SEL_W=1 and WIDTH=32, SEL_W=4 rerun of the route and broadcast tests → identical behaviour scaled.
- Mid-operation reset: rst_n=0 while 3 buffers are full → all clear in one edge, no out_valid pulses afterwards.

Source files
------------

// File: rtl/dmux_stream_pkg.sv
// Shared constants and helpers for the registered valid/ready demultiplexer.
package dmux_stream_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned SEL_W_DEF = 3;

    // Number of output channels addressed by a select of the given width.
    function automatic int unsigned chan_count(input int unsigned sel_w);
        return 32'(1) << sel_w;
    endfunction

    // Low bit of channel k's slice inside the packed output data bus.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry output buffer for a single demux channel; idle slots present zero data.
module stream_slot
    import dmux_stream_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             free_out
);

    // Slot can take a word when empty or when its current word leaves this cycle.
    assign free_out = ~valid_out | ready_in;

    // Load wins over drain so a same-cycle drain+refill keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= data_in;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// Registered N-way demultiplexer with per-channel one-entry buffers and broadcast.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEF,
    parameter  int unsigned SEL_W = SEL_W_DEF,
    localparam int unsigned N     = chan_count(SEL_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               busy
);

    logic [N-1:0] target;
    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         accept;

    // One-hot destination decode; broadcast targets every channel.
    always_comb begin
        target = '0;
        if (in_bcast) begin
            target = '1;
        end else begin
            target[in_sel] = 1'b1;
        end
    end

    // Broadcast is all-or-nothing, so it needs every slot free at once.
    always_comb begin
        in_ready = free[in_sel];
        if (in_bcast) begin
            in_ready = &free;
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = target & {N{accept}};

    for (genvar k = 0; k < N; k++) begin : g_slot
        stream_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .data_in  (in_data),
            .ready_in (out_ready[k]),
            .valid_out(out_valid[k]),
            .data_out (out_data[slice_lo(k, WIDTH) +: WIDTH]),
            .free_out (free[k])
        );
    end

    // Busy tracks the next occupancy so it always equals |out_valid from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |(load | (out_valid & ~out_ready));
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream: directed cases plus random streaming vs a queue model.
module tb_dmux_stream;

    localparam int unsigned W = 16;
    localparam int unsigned S = 3;
    localparam int unsigned N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [S-1:0]   in_sel;
    logic           in_bcast;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
    logic           busy;

    // Narrow instance: WIDTH=8, SEL_W=1
    logic        s_in_valid, s_in_ready, s_in_bcast, s_busy;
    logic [7:0]  s_in_data;
    logic [0:0]  s_in_sel;
    logic [1:0]  s_out_valid, s_out_ready;
    logic [15:0] s_out_data;

    // Wide instance: WIDTH=32, SEL_W=4
    logic         l_in_valid, l_in_ready, l_in_bcast, l_busy;
    logic [31:0]  l_in_data;
    logic [3:0]   l_in_sel;
    logic [15:0]  l_out_valid, l_out_ready;
    logic [511:0] l_out_data;

    dmux_stream u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    dmux_stream #(.WIDTH(8), .SEL_W(1)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_sel(s_in_sel), .in_bcast(s_in_bcast),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    dmux_stream #(.WIDTH(32), .SEL_W(4)) u_large (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_data(l_in_data), .in_sel(l_in_sel), .in_bcast(l_in_bcast),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-channel queue of words delivered but not yet drained.
    logic [W-1:0] q [N][$];
    int           pushed = 0;
    int           popped = 0;
    bit           last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare outputs against the model at negedge, then advance one clock and update the model.
    task automatic step();
        logic [N-1:0] ev;
        logic [W-1:0] ed;
        bit           er;
        @(negedge clk);
        for (int k = 0; k < N; k++) ev[k] = (q[k].size() != 0);
        check("out_valid", 64'(out_valid), 64'(ev));
        check("busy", 64'(busy), 64'(|ev));
        for (int k = 0; k < N; k++) begin
            ed = ev[k] ? q[k][0] : '0;
            check($sformatf("slice%0d", k), 64'(out_data[k*W +: W]), 64'(ed));
        end
        if (in_bcast) begin
            er = 1'b1;
            for (int k = 0; k < N; k++) if (ev[k] && !out_ready[k]) er = 1'b0;
        end else begin
            er = !ev[in_sel] || out_ready[in_sel];
        end
        check("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        last_acc = 1'b0;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) q[k].delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (ev[k] && out_ready[k]) begin
                    void'(q[k].pop_front());
                    popped++;
                end
            end
            if (in_valid && er) begin
                last_acc = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (in_bcast || k == int'(in_sel)) begin
                        q[k].push_back(in_data);
                        pushed++;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        int sent;
        int cyc;
        int cnt;

        rst_n = 1'b0;  in_valid = 1'b1; in_data = 16'h5555; in_sel = 3'd1; in_bcast = 1'b0;
        out_ready = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_sel = '0; s_in_bcast = 1'b0; s_out_ready = '0;
        l_in_valid = 1'b0; l_in_data = '0; l_in_sel = '0; l_in_bcast = 1'b0; l_out_ready = '0;

        // Reset held for two edges with a valid word presented
        @(posedge clk); #1;
        step();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_data[63:0] | out_data[127:64]), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'h1);
        step();

        // Single route to channel 5, then drain
        in_sel = 3'd5; in_data = 16'hBEEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("route_valid", 64'(out_valid), 64'h20);
        check("route_slice5", 64'(out_data[5*W +: W]), 64'hBEEF);
        check("route_busy", 64'(busy), 64'h1);
        step();
        out_ready = 8'h20;
        step();
        check("route_drained", 64'(out_valid), 64'h0);
        check("route_zero", 64'(out_data[5*W +: W]), 64'h0);
        out_ready = '0;

        // Back-pressure on channel 2
        in_sel = 3'd2; in_data = 16'h0A0A; in_valid = 1'b1;
        step();
        in_data = 16'h0B0B;
        #1 check("bp_blocked", 64'(in_ready), 64'h0);
        step();
        check("bp_held", 64'(out_data[2*W +: W]), 64'h0A0A);
        in_sel = 3'd3; in_data = 16'h0303;
        #1 check("bp_other", 64'(in_ready), 64'h1);
        step();
        out_ready = 8'h04; in_sel = 3'd2; in_data = 16'h0002;
        #1 check("bp_refill_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check("bp_refill_valid", 64'(out_valid), 64'h0C);
        check("bp_refill_data", 64'(out_data[2*W +: W]), 64'h0002);
        out_ready = '1;
        step();
        out_ready = '0;

        // Broadcast blocked by stalled channel 7
        in_sel = 3'd7; in_data = 16'h7777; in_valid = 1'b1;
        step();
        in_bcast = 1'b1; in_data = 16'h1234;
        #1 check("bc_blocked", 64'(in_ready), 64'h0);
        step();
        step();
        check("bc_no_partial", 64'(out_valid), 64'h80);
        out_ready = 8'h80;
        #1 check("bc_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
        check("bc_all_valid", 64'(out_valid), 64'hFF);
        for (int k = 0; k < N; k++)
            check($sformatf("bc_slice%0d", k), 64'(out_data[k*W +: W]), 64'h1234);
        out_ready = '1;
        step();

        // Random streaming with random back-pressure
        sent = 0; cyc = 0; in_valid = 1'b0;
        while (sent < 64 && cyc < 2000) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = S'($urandom);
                in_data  = W'($urandom);
                in_bcast = ($urandom_range(0, 15) == 0);
            end
            out_ready = N'($urandom);
            step();
            if (last_acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        check("stream_sent", 64'(sent), 64'd64);
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
        step();
        step();
        check("stream_balance", 64'(popped), 64'(pushed));

        // Full rate with all downstream ready
        cnt = 0; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sel = S'($urandom); in_data = W'($urandom);
            step();
            if (last_acc) cnt++;
        end
        check("full_rate", 64'(cnt), 64'd16);
        in_valid = 1'b0;
        step();

        // Reset while three buffers hold words
        out_ready = '0; in_valid = 1'b1;
        in_sel = 3'd1; in_data = 16'h1111; step();
        in_sel = 3'd4; in_data = 16'h4444; step();
        in_sel = 3'd6; in_data = 16'h6666; step();
        in_valid = 1'b0;
        check("mid_full", 64'(out_valid), 64'h52);
        rst_n = 1'b0;
        step();
        check("mid_cleared", 64'(out_valid), 64'h0);
        check("mid_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_ready = N'($urandom);
            step();
        end

        // Narrow instance: route and broadcast
        s_in_sel = 1'b1; s_in_data = 8'hA5; s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        check("s_route_valid", 64'(s_out_valid), 64'h2);
        check("s_route_data", 64'(s_out_data), 64'hA500);
        check("s_route_busy", 64'(s_busy), 64'h1);
        s_out_ready = 2'b10;
        step();
        check("s_drain_valid", 64'(s_out_valid), 64'h0);
        check("s_drain_data", 64'(s_out_data), 64'h0);
        s_out_ready = 2'b00; s_in_sel = 1'b0; s_in_data = 8'h11; s_in_valid = 1'b1;
        step();
        s_in_bcast = 1'b1; s_in_data = 8'h3C;
        #1 check("s_bc_blocked", 64'(s_in_ready), 64'h0);
        step();
        check("s_bc_no_partial", 64'(s_out_valid), 64'h1);
        check("s_bc_held", 64'(s_out_data), 64'h0011);
        s_out_ready = 2'b01;
        #1 check("s_bc_ready", 64'(s_in_ready), 64'h1);
        step();
        s_in_valid = 1'b0; s_in_bcast = 1'b0; s_out_ready = 2'b00;
        check("s_bc_valid", 64'(s_out_valid), 64'h3);
        check("s_bc_data", 64'(s_out_data), 64'h3C3C);

        // Wide instance: route and broadcast
        l_in_sel = 4'd13; l_in_data = 32'hDEADBEEF; l_in_valid = 1'b1;
        step();
        check("l_route_valid", 64'(l_out_valid), 64'h2000);
        check("l_route_data", 64'(l_out_data[13*32 +: 32]), 64'hDEADBEEF);
        check("l_route_other", 64'(l_out_data[12*32 +: 32]), 64'h0);
        l_out_ready = '1; l_in_bcast = 1'b1; l_in_data = 32'hCAFEF00D;
        #1 check("l_bc_ready", 64'(l_in_ready), 64'h1);
        step();
        l_in_valid = 1'b0; l_in_bcast = 1'b0;
        check("l_bc_valid", 64'(l_out_valid), 64'hFFFF);
        check("l_bc_data0", 64'(l_out_data[31:0]), 64'hCAFEF00D);
        check("l_bc_data15", 64'(l_out_data[15*32 +: 32]), 64'hCAFEF00D);
        step();
        check("l_bc_drained", 64'(l_out_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
